alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU with a valid/ready handshake on its input and output sides.
//   It keeps the existing ADD/SUB/AND/OR op encoding and carry convention, and adds XOR,
//   multi-cycle shifts, an optional shift-add multiply, and registered status flags.
//   It sits between the operand/decode stage and the writeback stage.
// PARAMETERS
//   WIDTH  8  operand/result width; power of 2, >= 4
//   SHW    $clog2(WIDTH)  shift-amount width (derived; do not override)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and op presented
//   in_ready   out  1      block can accept (state==IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B; for shifts, b[SHW-1:0] is the amount
//   op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer takes the result
//   result     out  WIDTH  registered result
//   cout       out  1      carry / last bit shifted out / multiply overflow
//   zero       out  1      result == 0
//   ovf        out  1      signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//   - Reset (async assert, sync deassert): state=IDLE; result, cout, zero, ovf, out_valid = 0;
//     in_ready = 1.
//   - FSM states: IDLE, EXEC, DONE.
//   - IDLE: on in_valid && in_ready, latch a, b and op.
//     - ADD..XOR: result computed; go to DONE. out_valid rises 1 cycle after accept.
//     - SHL/SHR with amount 0: result = a, cout = 0, go to DONE (latency 1).
//     - SHL/SHR with amount n > 0: go to EXEC; n more cycles (latency n+1).
//     - MUL: go to EXEC (latency WIDTH+1), only when ALU_SEQ_MUL_EN is defined.
//   - EXEC, shifts: one bit position per cycle, logical (zero fill).
//     cout = the bit shifted out on the final step. Go to DONE when the remaining count
//     reaches 0.
//   - EXEC, MUL: unsigned shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
//     result = low WIDTH bits; cout = |high WIDTH bits.
//   - DONE: out_valid=1, in_ready=0. result and flags hold stable until out_valid && out_ready,
//     then go to IDLE. No new accept is possible in the same cycle, so back-to-back ops cost
//     1 idle cycle.
//   - ADD: {cout,result} = a+b.
//   - SUB: {cout,result} = a + ~b + 1. cout=1 means no borrow.
//   - ovf = (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), where b' = b for ADD and ~b for SUB.
//   - AND/OR/XOR: cout = 0, ovf = 0.
//   - zero is computed from the final result for every op, and is registered with it.
//   - in_valid while in_ready=0 is ignored; a, b and op need not be held after accept.
//   - Reset asserted in EXEC or DONE aborts the op. The pending result is discarded and no
//     out_valid pulse is produced.
//   - out_valid never goes high without a preceding accept; exactly one result per accept.
// CONFIGURATION
//   ALU_SEQ_MUL_EN defined:
//     op 111 = multi-cycle multiply as above.
//   ALU_SEQ_MUL_EN undefined:
//     - op 111 is illegal: result = 0, cout = 0, ovf = 0, zero = 1, latency 1.
//     - No accumulator or multiply logic is synthesised.
// TESTING (WIDTH=8)
//   1. ADD a=FF b=01 -> result=00 cout=1 zero=1 ovf=0, out_valid 1 cycle after accept.
//   2. SUB a=80 b=01 -> result=7F cout=1 ovf=1. SUB a=00 b=01 -> result=FF cout=0 ovf=0.
//   3. SHL a=81 b=03 -> result=08 cout=0, latency 4.
//      SHR a=05 b=01 -> result=02 cout=1, latency 2.
//      SHL b=00 -> result=a, latency 1.
//   4. Backpressure: hold out_ready=0 for 5 cycles after out_valid ->
//      - result and flags stable, in_ready=0;
//      - an in_valid pulse in that window is ignored (no second result);
//      - release out_ready -> IDLE next cycle.
//   5. Reset mid-op: SHR b=07, assert rst_n=0 on the 3rd EXEC cycle ->
//      - all outputs 0 immediately, in_ready=1;
//      - no out_valid after release.
//   6. MUL a=10 b=11 -> result=10 cout=1, latency 9 (with ALU_SEQ_MUL_EN).
//      Without the macro -> result=00 zero=1, latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/op request and result/flags response bundle between decode and writeback.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, zero, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: 1-cycle arith/logic, n+1-cycle shifts, WIDTH+1-cycle multiply under ALU_SEQ_MUL_EN.
// Result and flags hold in DONE until out_ready; in_ready only in IDLE.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shl_v, shr_v;
  logic             last_step;

  logic [WIDTH-1:0] alu_res;
  logic             alu_cout, alu_ovf, alu_multi;
  logic [SHW:0]     start_cnt;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mstep;

  // Upper half gathers the partial products; lower half drains the multiplier bits.
  assign mstep = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
`endif

  assign is_sub    = (bus.op == OP_SUB);
  assign b_eff     = is_sub ? ~bus.b : bus.b;
  assign sum       = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign shamt     = bus.b[SHW-1:0];
  assign shl_v     = {work_q[MSB-1:0], 1'b0};
  assign shr_v     = {1'b0, work_q[MSB:1]};
  assign last_step = (cnt_q == (SHW+1)'(1));

  always_comb begin
    alu_res   = '0;
    alu_cout  = 1'b0;
    alu_ovf   = 1'b0;
    alu_multi = 1'b0;
    start_cnt = {1'b0, shamt};
    case (bus.op)
      OP_ADD, OP_SUB: begin
        alu_res  = sum[MSB:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (bus.a[MSB] == b_eff[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL, OP_SHR: begin
        alu_res   = bus.a;
        alu_multi = (shamt != '0);
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        alu_multi = 1'b1;
        start_cnt = (SHW+1)'(WIDTH);
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d   = bus.op;
          work_d = bus.a;
          cnt_d  = start_cnt;
`ifdef ALU_SEQ_MUL_EN
          acc_d   = {{WIDTH{1'b0}}, bus.b};
          mcand_d = bus.a;
`endif
          if (alu_multi) begin
            state_d = EXEC;
          end else begin
            result_d = alu_res;
            cout_d   = alu_cout;
            ovf_d    = alu_ovf;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - (SHW+1)'(1);
        case (op_q)
          OP_SHL, OP_SHR: begin
            work_d = (op_q == OP_SHL) ? shl_v : shr_v;
            if (last_step) begin
              result_d = work_d;
              cout_d   = (op_q == OP_SHL) ? work_q[MSB] : work_q[0];
              zero_d   = (work_d == '0);
              ovf_d    = 1'b0;
              state_d  = DONE;
            end
          end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: begin
            acc_d = {mstep, acc_q[WIDTH-1:1]};
            if (last_step) begin
              result_d = acc_d[MSB:0];
              cout_d   = |acc_d[2*WIDTH-1:WIDTH];
              zero_d   = (acc_d[MSB:0] == '0);
              ovf_d    = 1'b0;
              state_d  = DONE;
            end
          end
`endif
          default: state_d = IDLE;
        endcase
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule
